// File: rtl/rtc_pkg.sv
// rtc_pkg: shared address map, field limits, time record and helpers for the RTC register block
package rtc_pkg;
  localparam logic [7:0] ADDR_CURR_TIME = 8'h00;
  localparam logic [7:0] ADDR_ADD_ALARM = 8'h04;
  localparam logic [7:0] ADDR_ADJ_TIME = 8'h08;
  localparam logic [7:0] ADDR_ALARM_CLR = 8'h0C;
  localparam logic [7:0] ADDR_ALARM_BASE = 8'h10;
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HR_MAX = 5'd23;
  localparam logic [8:0] DAY_MAX = 9'd364;
  localparam logic [5:0] YR_MAX = 6'd63;
  // Field order matches the curr_time bit layout, so the struct packs straight onto the word
  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic [8:0] day;
    logic [5:0] yr;
  } rtc_time_t;
  typedef enum logic [1:0] {IDLE, ACCESS, ADJUST} rtc_state_e;
  function automatic logic [31:0] pack_time(rtc_time_t t);
    return t;
  endfunction
  function automatic rtc_time_t unpack_time(logic [31:0] w);
    return w;
  endfunction
endpackage

// File: rtl/rtc_time_step.sv
// rtc_time_step: combinational one-second increment or decrement with carry/borrow across all fields
module rtc_time_step
  import rtc_pkg::*;
(
  input  rtc_time_t t,
  input  logic      dec,
  output rtc_time_t q
);
  logic c_min, c_hr, c_day, c_yr;
  always_comb begin
    c_min = dec ? t.sec == '0 : t.sec == SEC_MAX;
    c_hr = c_min && (dec ? t.min == '0 : t.min == MIN_MAX);
    c_day = c_hr && (dec ? t.hr == '0 : t.hr == HR_MAX);
    c_yr = c_day && (dec ? t.day == '0 : t.day == DAY_MAX);
    q.sec = c_min ? (dec ? SEC_MAX : '0) : (dec ? t.sec - 6'd1 : t.sec + 6'd1);
    q.min = !c_min ? t.min : c_hr ? (dec ? MIN_MAX : '0) : (dec ? t.min - 6'd1 : t.min + 6'd1);
    q.hr = !c_hr ? t.hr : c_day ? (dec ? HR_MAX : '0) : (dec ? t.hr - 5'd1 : t.hr + 5'd1);
    q.day = !c_day ? t.day : c_yr ? (dec ? DAY_MAX : '0) : (dec ? t.day - 9'd1 : t.day + 9'd1);
    q.yr = !c_yr ? t.yr : dec ? (t.yr == '0 ? YR_MAX : t.yr - 6'd1) : (t.yr == YR_MAX ? '0 : t.yr + 6'd1);
  end
endmodule

// File: rtl/rtc_apb_regs.sv
// rtc_apb_regs: bus-slave calendar counters, alarm slots and stalling time adjustment
module rtc_apb_regs
  import rtc_pkg::*;
#(
  parameter int TICKS_PER_SEC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        enable,
  input  logic        write,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic [31:0] sec,
  output logic [31:0] min,
  output logic [31:0] hr,
  output logic [31:0] day,
  output logic [31:0] yr,
  output logic [31:0] curr_time,
  output logic [31:0] alarm1,
  output logic [31:0] alarm2,
  output logic [31:0] alarm3,
  output logic [31:0] alarm4,
  output logic [3:0]  alarm_irq
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  rtc_state_e state, state_nx;
  logic [PW-1:0] presc;
  logic [16:0] delta;
  logic adj_dec;
  rtc_time_t now, now_nx, stepped, wt;
  logic [31:0] alarm [4];
  logic [31:0] rd_mux;
  logic [3:0] add_sel, clr, match;
  logic access, wr, do_adj, wr_time, add_en, tick, step_en, load;
  rtc_time_step u_step (.t(now), .dec(state == ADJUST && adj_dec), .q(stepped));
  always_comb begin
    wt = unpack_time(wdata);
    access = state == IDLE && sel && enable;
    wr = access && write;
    do_adj = wr && addr == ADDR_ADJ_TIME && wdata[16:0] != '0;
    wr_time = wr && addr == ADDR_CURR_TIME && wt.sec <= SEC_MAX && wt.min <= MIN_MAX && wt.hr <= HR_MAX && wt.day <= DAY_MAX;
    add_en = wr && addr == ADDR_ADD_ALARM;
    clr = wr && addr == ADDR_ALARM_CLR ? wdata[3:0] : '0;
    tick = state != ADJUST && presc == PMAX;
    step_en = state == ADJUST && delta != '0;
    load = wr_time || tick || step_en;
    now_nx = wr_time ? wt : (tick || step_en) ? stepped : now;
    state_nx = access ? (do_adj ? ADJUST : ACCESS) : (state == ACCESS || (state == ADJUST && delta == '0)) ? IDLE : state;
    rd_mux = write ? '0 : addr == ADDR_CURR_TIME ? pack_time(now) : (addr[7:4] == ADDR_ALARM_BASE[7:4] && addr[1:0] == 2'b00) ? alarm[addr[3:2]] : '0;
    add_sel = '0;
    match = '0;
    for (int i = 3; i >= 0; i--) if (!alarm[i][14]) add_sel = 4'b0001 << i;
    for (int i = 0; i < 4; i++) match[i] = load && alarm[i][14] && alarm[i][31:15] == {now_nx.hr, now_nx.min, now_nx.sec};
  end
  always_ff @(posedge clk) state <= !reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
      delta <= '0;
      adj_dec <= 1'b0;
      now <= '0;
      alarm <= '{default: '0};
      alarm_irq <= '0;
      ready <= 1'b0;
      rdata <= '0;
    end else begin
      presc <= state == ADJUST ? presc : (wr_time || tick) ? '0 : presc + 1'b1;
      delta <= do_adj ? wdata[16:0] : step_en ? delta - 17'd1 : delta;
      adj_dec <= do_adj ? wdata[31] : adj_dec;
      now <= now_nx;
      for (int i = 0; i < 4; i++) alarm[i] <= clr[i] ? '0 : (add_en && add_sel[i]) ? {wdata[31:15], 1'b1, 14'b0} : alarm[i];
      alarm_irq <= (alarm_irq | match) & ~clr;
      // An adjustment's ready is raised by the step that empties the counter
      ready <= (access && !do_adj) || (step_en && delta == 17'd1);
      rdata <= access ? rd_mux : '0;
    end
  end
  assign sec = 32'(now.sec);
  assign min = 32'(now.min);
  assign hr = 32'(now.hr);
  assign day = 32'(now.day);
  assign yr = 32'(now.yr);
  assign curr_time = pack_time(now);
  assign alarm1 = alarm[0];
  assign alarm2 = alarm[1];
  assign alarm3 = alarm[2];
  assign alarm4 = alarm[3];
endmodule

// File: tb/tb_rtc_apb_regs.sv
// tb_rtc_apb_regs: randomized bus traffic against a seconds-count reference model with a ready-driven scoreboard
module tb_rtc_apb_regs;
  localparam int T = 4;
  localparam longint DAY = 86400;
  localparam longint YEAR = 365 * DAY;
  localparam longint TOTAL = 64 * YEAR;
  logic clk = 0, reset = 0, sel = 0, enable = 0, write = 0;
  logic [7:0] addr = 0;
  logic [31:0] wdata = 0;
  logic ready;
  logic [31:0] rdata, sec, min, hr, day, yr, curr_time, alarm1, alarm2, alarm3, alarm4;
  logic [3:0] alarm_irq;
  rtc_apb_regs #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .sec(sec), .min(min), .hr(hr), .day(day), .yr(yr), .curr_time(curr_time),
    .alarm1(alarm1), .alarm2(alarm2), .alarm3(alarm3), .alarm4(alarm4), .alarm_irq(alarm_irq)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0, fails = 0;
  bit started = 0;
  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] rd;
    logic [31:0] ct;
    logic [3:0] irq;
    logic [127:0] al;
  } exp_t;
  exp_t q[$];
  exp_t got;
  // Reference model: time as a single count of seconds since 00:00:00 day 0 year 0
  longint m_s;
  int m_p;
  logic [31:0] m_al [4];
  logic [3:0] m_irq;
  logic [7:0] addrs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'hFC};

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] mk(int h, int m, int s, int d, int y);
    return {5'(h), 6'(m), 6'(s), 9'(d), 6'(y)};
  endfunction

  function automatic logic [31:0] to_ct(longint s);
    longint r;
    r = s % YEAR;
    return {5'(r % DAY / 3600), 6'(r % 3600 / 60), 6'(r % 60), 9'(r / DAY), 6'(s / YEAR)};
  endfunction

  function automatic longint of_ct(logic [31:0] c);
    return longint'(c[5:0]) * YEAR + longint'(c[14:6]) * DAY + longint'(c[31:27]) * 3600 + longint'(c[26:21]) * 60 + longint'(c[20:15]);
  endfunction

  function automatic void m_reset();
    m_s = 0;
    m_p = 0;
    m_irq = 0;
    for (int i = 0; i < 4; i++) m_al[i] = 0;
  endfunction

  function automatic void m_load(longint s);
    logic [31:0] c;
    m_s = s;
    c = to_ct(s);
    for (int i = 0; i < 4; i++) if (m_al[i][14] && m_al[i][31:15] == c[31:15]) m_irq[i] = 1'b1;
  endfunction

  function automatic void m_tick();
    if (m_p == T - 1) begin
      m_p = 0;
      m_load((m_s + 1) % TOTAL);
    end else m_p++;
  endfunction

  function automatic void m_step(logic dec);
    m_load(dec ? (m_s == 0 ? TOTAL - 1 : m_s - 1) : (m_s + 1) % TOTAL);
  endfunction

  function automatic logic [31:0] m_access(logic w, logic [7:0] a, logic [31:0] d);
    logic [31:0] rd;
    logic found;
    rd = 0;
    found = 0;
    if (!w && a == 8'h00) rd = to_ct(m_s);
    if (!w && a inside {8'h10, 8'h14, 8'h18, 8'h1C}) rd = m_al[(a - 8'h10) / 4];
    if (w && a == 8'h00 && d[20:15] < 60 && d[26:21] < 60 && d[31:27] < 24 && d[14:6] < 365) begin
      m_p = 0;
      m_load(of_ct(d));
    end else m_tick();
    if (w && a == 8'h0C) for (int i = 0; i < 4; i++) if (d[i]) begin m_al[i] = 0; m_irq[i] = 0; end
    if (w && a == 8'h04) for (int i = 0; i < 4; i++) if (!found && !m_al[i][14]) begin m_al[i] = {d[31:15], 1'b1, 14'b0}; found = 1; end
    return rd;
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      sel = 0; enable = 0; write = 0;
      m_tick();
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic xfer(logic w, logic [7:0] a, logic [31:0] d);
    exp_t x;
    int dl;
    sel = 1; enable = 1; write = w; addr = a; wdata = d;
    dl = (w && a == 8'h08) ? int'(d[16:0]) : 0;
    x.rd = m_access(w, a, d);
    for (int k = 0; k < dl; k++) begin
      @(posedge clk); @(negedge clk);
      m_step(d[31]);
    end
    x.cyc = 32'(cyc + 1);
    x.ct = to_ct(m_s);
    x.irq = m_irq;
    x.al = {m_al[3], m_al[2], m_al[1], m_al[0]};
    q.push_back(x);
    @(posedge clk); @(negedge clk);
    if (dl == 0) m_tick();
    @(posedge clk); @(negedge clk);
    sel = 0; enable = 0; write = 0;
  endtask

  task automatic check_now(string tag);
    logic [31:0] c;
    c = to_ct(m_s);
    chk({tag, "_curr_time"}, curr_time, c);
    chk({tag, "_sec"}, sec, 32'(c[20:15]));
    chk({tag, "_min"}, min, 32'(c[26:21]));
    chk({tag, "_hr"}, hr, 32'(c[31:27]));
    chk({tag, "_day"}, day, 32'(c[14:6]));
    chk({tag, "_yr"}, yr, 32'(c[5:0]));
    chk({tag, "_irq"}, 32'(alarm_irq), 32'(m_irq));
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_curr_time"}, curr_time, 0);
    chk({tag, "_fields"}, sec | min | hr | day | yr, 0);
    chk({tag, "_alarm1"}, alarm1, 0);
    chk({tag, "_alarm2"}, alarm2, 0);
    chk({tag, "_alarm3"}, alarm3, 0);
    chk({tag, "_alarm4"}, alarm4, 0);
    chk({tag, "_irq"}, 32'(alarm_irq), 0);
  endtask

  always @(negedge clk) if (started) begin
    if (ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got ready=1 at cycle %0d, expected no transfer completing", cyc);
      end else begin
        got = q.pop_front();
        chk("ready_cycle", 32'(cyc), got.cyc);
        chk("rdata", rdata, got.rd);
        chk("curr_time_at_ready", curr_time, got.ct);
        chk("irq_at_ready", 32'(alarm_irq), 32'(got.irq));
        chk("alarm1_at_ready", alarm1, got.al[31:0]);
        chk("alarm2_at_ready", alarm2, got.al[63:32]);
        chk("alarm3_at_ready", alarm3, got.al[95:64]);
        chk("alarm4_at_ready", alarm4, got.al[127:96]);
      end
    end else chk("rdata_zero_without_ready", rdata, 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end of stimulus");
    $fatal(1);
  end

  initial begin
    logic [31:0] c;
    int f;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    m_reset();
    reset = 1;
    started = 1;
    xfer(1, 8'h00, mk(23, 59, 59, 364, 63));
    check_now("full_time");
    idle(T);
    chk("full_wrap", curr_time, 0);
    check_now("after_wrap");
    xfer(0, 8'h00, 0);
    xfer(1, 8'h00, mk(1, 2, 60, 3, 4));
    xfer(0, 8'h00, 0);
    xfer(1, 8'h00, mk(0, 0, 0, 0, 0));
    for (int v = 5; v <= 9; v++) xfer(1, 8'h04, mk(0, 0, v, 0, 0));
    for (int i = 0; i < 4; i++) xfer(0, 8'h10 + 8'(4 * i), 0);
    while (m_s < 5) idle(1);
    chk("alarm1_hit", 32'(alarm_irq), 32'b0001);
    check_now("alarm_hit");
    xfer(1, 8'h0C, 32'h1);
    chk("alarm1_cleared", alarm1, 0);
    chk("irq0_cleared", 32'(alarm_irq[0]), 0);
    xfer(1, 8'h00, mk(0, 0, 1, 0, 0));
    xfer(1, 8'h08, 32'h8000_0003);
    chk("adj_sub3", curr_time, mk(23, 59, 58, 364, 63));
    check_now("adj_sub3");
    xfer(0, 8'h20, 0);
    while (m_p != T - 1) idle(1);
    xfer(1, 8'h00, mk(12, 0, 0, 0, 0));
    chk("tick_vs_write", curr_time, mk(12, 0, 0, 0, 0));
    sel = 1; enable = 1; write = 1; addr = 8'h08; wdata = 32'd10;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    reset = 0; sel = 0; enable = 0; write = 0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check_reset_outputs("mid_adjust_reset");
    m_reset();
    reset = 1;
    xfer(0, 8'h00, 0);
    xfer(1, 8'h08, 32'h0000_0002);
    check_now("post_reset_adj");
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: xfer(0, addrs[$urandom_range(0, 9)], $urandom);
        1: xfer(1, 8'h00, mk($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 364), $urandom_range(0, 63)));
        2: begin
          c = mk($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 364), $urandom_range(0, 63));
          f = $urandom_range(0, 3);
          if (f == 0) c[20:15] = 6'($urandom_range(60, 63));
          if (f == 1) c[26:21] = 6'($urandom_range(60, 63));
          if (f == 2) c[31:27] = 5'($urandom_range(24, 31));
          if (f == 3) c[14:6] = 9'($urandom_range(365, 511));
          xfer(1, 8'h00, c);
        end
        3: begin
          c = to_ct((m_s + longint'($urandom_range(0, 8))) % TOTAL);
          xfer(1, 8'h04, {c[31:15], 15'($urandom)});
        end
        4: xfer(1, 8'h08, {1'($urandom_range(0, 1)), 14'($urandom), 17'($urandom_range(0, 6))});
        5: xfer(1, 8'h0C, $urandom);
        6: xfer(1, addrs[$urandom_range(4, 9)], $urandom);
        default: idle($urandom_range(1, 6));
      endcase
      idle($urandom_range(0, 2));
    end
    check_now("final");
    idle(5);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rtc_apb_regs.md
# rtc_apb_regs

Bus-slave register block of the real-time-clock/alarm design. It sits between the APB-style bus and the scoreboard/monitor: it decodes bus transfers and keeps the calendar counters (sec/min/hr/day/yr and packed curr_time) plus four alarm slots. It advances time on a prescaled tick, applies multi-second adjustments through a stalling state machine, and raises sticky alarm flags. Every register output is visible to the checker through the registers interface.

## Interface
- TICKS_PER_SEC, default 4: clk cycles per one-second tick; legal range ≥1.
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low.
- sel, enable, write  in  1 each  bus setup/access/direction.
- addr  in  8  byte address.
- wdata  in  32  write data.
- ready  out  1  transfer complete, registered.
- rdata  out  32  read data, valid while ready=1, else 0.
- sec, min, hr, day, yr  out  32 each  zero-extended fields.
- curr_time  out  32  {hr[4:0], min[5:0], sec[5:0], day[8:0], yr[5:0]}, bits 31:27 / 26:21 / 20:15 / 14:6 / 5:0.
- alarm1..alarm4  out  32 each  {hh:mm:ss[16:0] at 31:15, valid at 14, 14'b0}.
- alarm_irq  out  4  sticky match flags, bit n-1 = alarm n.

## Operation
- Address map:
  - 0x00 CURR_TIME: R/W.
  - 0x04 ADD_ALARM: W. wdata[31:15] goes to the lowest-numbered slot with valid=0, and that slot's valid is set.
  - 0x08 ADJ_TIME: W. wdata[31]=1 subtracts, 0 adds; wdata[16:0] = delta seconds.
  - 0x0C ALARM_CLR: W. wdata[3:0] mask clears the slot (register=0) and its irq bit.
  - 0x10/0x14/0x18/0x1C: R, alarm1..4.
- Unmapped address, read of a write-only address, or write to a read-only address: ready still pulses, rdata=0, no state change.
- CURR_TIME write with any field out of range (sec>59, min>59, hr>23, day>364) is ignored entirely.
- yr is 0..63.
- Step rules:
  - +1 s: sec 59→0 carries to min, min 59→0 carries to hr, hr 23→0 carries to day, day 364→0 carries to yr, yr 63→0.
  - −1 s: borrows symmetrically; the full wrap is 0 → {23,59,59,364,63}.
- ADD_ALARM with all four slots valid is dropped.
- Duplicate alarm values are allowed.
- Alarm match: on any cycle the time registers change, if the new curr_time[31:15] equals alarmN[31:15] and alarmN[14]=1, set alarm_irq[N-1]. The flag holds until ALARM_CLR or reset.
- FSM:
  - IDLE: sel&enable → ACCESS. An access with ADJ_TIME and delta≠0 → ADJUST instead.
  - ACCESS: one cycle; ready=1; → IDLE.
  - ADJUST: one ±1 s step per cycle, delta counter decrements. When the counter reaches 0, ready=1 for one cycle → IDLE. ADJ_TIME with delta=0 behaves like ACCESS.
- Tick: the prescaler counts 0..TICKS_PER_SEC−1 and steps +1 s on wrap. The prescaler is frozen in ADJUST.
- Simultaneous tick and CURR_TIME write: the write wins and the prescaler restarts at 0.

## Timing
- Reset (reset=0 at an edge): all outputs 0, FSM IDLE, prescaler 0, delta 0. Reset overrides any in-flight transfer or adjustment; no ready pulse is produced.
- Write latency: state commits on the edge ending the first access cycle (sel&enable sampled in IDLE). ready=1 in the following cycle, with the new value already on the outputs.
- Read latency: ready and rdata are both valid in the cycle after the first access cycle.
- ADJ_TIME with delta D≥1: ready rises D+1 cycles after the access cycle. The final time is visible in the same cycle as ready.
- Bus inputs are ignored while not in IDLE. The master holds sel/enable until ready.
- alarm_irq is set on the same edge that loads the matching time.

## Structure
- Package rtc_pkg:
  - address localparams;
  - field widths and maxima (SEC_MAX=59, MIN_MAX=59, HR_MAX=23, DAY_MAX=364, YR_MAX=63);
  - typedef struct packed rtc_time_t {hr, min, sec, day, yr};
  - typedef enum {IDLE, ACCESS, ADJUST} rtc_state_e;
  - pack/unpack functions.
- Sub-module rtc_time_step: combinational ±1 s with carry/borrow on rtc_time_t. It is shared by the tick path and the ADJUST path.

## Test plan
- Reset held 2 cycles mid-ADJUST → all outputs 0, ready 0, next transfer services normally.
- Write CURR_TIME 23:59:59 day 364 yr 63, then wait TICKS_PER_SEC cycles → curr_time=0, yr wraps to 0.
- Write CURR_TIME with sec=60 → ready pulses; a subsequent read returns the previous value unchanged.
- ADD_ALARM ×5 with 00:00:05..00:00:09 → slots 1–4 hold 5..8 with bit14=1; the fifth is dropped. After time reaches 00:00:05, alarm_irq=4'b0001. ALARM_CLR 0x1 → alarm1=0, irq=0.
- ADJ_TIME sub, delta 3, from 00:00:01 day 0 yr 0 → ready rises 4 cycles after the access; time = 23:59:58 day 364 yr 63.
- Read 0x20 → ready=1, rdata=0. Tick coinciding with a CURR_TIME write of 12:00:00 → curr_time shows 12:00:00 with no extra tick.
